// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ps2_pkg
// Description : Shared types, frame constants and parity helper for the
//               buffered PS/2 receiver.
// Revision    : 1.0 - initial release
// ============================================================================
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RX    = 2'd1,
        CHECK = 2'd2
    } state_t;

    // start bit is consumed in IDLE; the shift register holds data, parity, stop
    localparam int FRAME_BITS = 10;

    function automatic logic odd_parity_ok(input logic [7:0] data, input logic parity);
        return ^{data, parity};
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : First-word-fall-through FIFO; head entry is always on rd_data.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int              C_AW    = $clog2(DEPTH);
    localparam logic [C_AW:0]   C_DEPTH = (C_AW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [C_AW-1:0]  r_wr_ptr;
    logic [C_AW-1:0]  r_rd_ptr;
    logic [C_AW:0]    r_count;
    logic             w_do_wr;
    logic             w_do_rd;

    // a pop frees the slot, so a push into a full FIFO is legal alongside it
    assign w_do_rd = rd_en && (r_count != '0);
    assign w_do_wr = wr_en && ((r_count != C_DEPTH) || w_do_rd);

    always_ff @(posedge clk) begin
        if (w_do_wr) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_rd) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_wr, w_do_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign empty   = (r_count == '0);
    assign full    = (r_count == C_DEPTH);
    assign count   = r_count;
    assign rd_data = empty ? '0 : r_mem[r_rd_ptr];

endmodule
`default_nettype wire

// File: rtl/ps2_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : ps2_rx_fifo
// Description : Tick-sampled, filtered PS/2 receiver with frame checking and
//               a FWFT byte queue toward the CPU.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_rx_fifo
    import ps2_pkg::*;
#(
    parameter int CLK_DIV       = 25,
    parameter int FILTER_LEN    = 8,
    parameter int FIFO_DEPTH    = 16,
    parameter int TIMEOUT_TICKS = 2000
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          ps2c,
    input  logic                          ps2d,
    input  logic                          rx_en,
    input  logic                          rd_en,
    input  logic                          clr_err,
    output logic [7:0]                    rd_data,
    output logic                          empty,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          rx_done_tick,
    output logic                          parity_err,
    output logic                          overflow,
    output logic                          frame_err
);

    localparam int                 C_TICK_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [C_TICK_W-1:0] C_TICK_MAX = C_TICK_W'(CLK_DIV - 1);
    localparam int                 C_TO_W     = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [C_TO_W-1:0]  C_TO_LAST  = C_TO_W'(TIMEOUT_TICKS - 1);
    localparam logic [3:0]         C_BIT_LAST = 4'(FRAME_BITS - 1);

    logic                    r_ps2c_meta, r_ps2c_sync;
    logic                    r_ps2d_meta, r_ps2d_sync;
    logic [C_TICK_W-1:0]     r_tick_cnt;
    logic                    w_tick;
    logic [FILTER_LEN-1:0]   r_filter;
    logic [FILTER_LEN-1:0]   w_filter_next;
    logic                    r_filt_clk;
    logic                    w_fall;
    state_t                  r_state, w_state_next;
    logic [FRAME_BITS-1:0]   r_shift;
    logic [3:0]              r_bit_cnt;
    logic [C_TO_W-1:0]       r_to_cnt;
    logic                    w_start;
    logic                    w_timeout;
    logic                    w_push;
    logic                    w_frame_err_set;
    logic                    w_parity_set;
    logic                    w_overflow_set;
    logic                    w_full;
    logic                    r_rx_done;
    logic                    r_frame_err;
    logic                    r_parity_err;
    logic                    r_overflow;

    // idle-high reset value keeps the filter from seeing a false edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ps2c_meta <= 1'b1;
            r_ps2c_sync <= 1'b1;
            r_ps2d_meta <= 1'b1;
            r_ps2d_sync <= 1'b1;
        end else begin
            r_ps2c_meta <= ps2c;
            r_ps2c_sync <= r_ps2c_meta;
            r_ps2d_meta <= ps2d;
            r_ps2d_sync <= r_ps2d_meta;
        end
    end

    assign w_tick        = (r_tick_cnt == C_TICK_MAX);
    assign w_filter_next = {r_filter[FILTER_LEN-2:0], r_ps2c_sync};
    assign w_fall        = w_tick && r_filt_clk && (w_filter_next == '0);
    assign w_start       = w_fall && rx_en && !r_ps2d_sync;
    assign w_timeout     = w_tick && !w_fall && (r_to_cnt == C_TO_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tick_cnt <= '0;
            r_filter   <= '0;
            r_filt_clk <= 1'b0;
        end else begin
            r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 1'b1;
            if (w_tick) begin
                r_filter <= w_filter_next;
                if (&w_filter_next) begin
                    r_filt_clk <= 1'b1;
                end else if (w_filter_next == '0) begin
                    r_filt_clk <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_start) w_state_next = RX;
            RX: begin
                if (w_fall && (r_bit_cnt == C_BIT_LAST)) begin
                    w_state_next = CHECK;
                end else if (w_timeout) begin
                    w_state_next = IDLE;
                end
            end
            CHECK:   w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // stop error outranks parity, which outranks a full queue
    always_comb begin
        w_push          = 1'b0;
        w_frame_err_set = 1'b0;
        w_parity_set    = 1'b0;
        w_overflow_set  = 1'b0;
        case (r_state)
            RX:    w_frame_err_set = w_timeout;
            CHECK: begin
                if (!r_shift[9]) begin
                    w_frame_err_set = 1'b1;
                end else if (!odd_parity_ok(r_shift[7:0], r_shift[8])) begin
                    w_parity_set = 1'b1;
                end else if (w_full && !rd_en) begin
                    w_overflow_set = 1'b1;
                end else begin
                    w_push = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_to_cnt  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_bit_cnt <= '0;
                        r_to_cnt  <= '0;
                    end
                end
                RX: begin
                    if (w_fall) begin
                        r_shift   <= {r_ps2d_sync, r_shift[FRAME_BITS-1:1]};
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                        r_to_cnt  <= '0;
                    end else if (w_tick) begin
                        r_to_cnt  <= r_to_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rx_done    <= 1'b0;
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_rx_done   <= w_push;
            r_frame_err <= w_frame_err_set;
            if (w_parity_set) begin
                r_parity_err <= 1'b1;
            end else if (clr_err) begin
                r_parity_err <= 1'b0;
            end
            if (w_overflow_set) begin
                r_overflow <= 1'b1;
            end else if (clr_err) begin
                r_overflow <= 1'b0;
            end
        end
    end

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (w_push),
        .wr_data (r_shift[7:0]),
        .rd_en   (rd_en),
        .rd_data (rd_data),
        .empty   (empty),
        .full    (w_full),
        .count   (count)
    );

    assign full         = w_full;
    assign rx_done_tick = r_rx_done;
    assign frame_err    = r_frame_err;
    assign parity_err   = r_parity_err;
    assign overflow     = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_ps2_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_ps2_rx_fifo
// Description : Directed self-checking bench for ps2_rx_fifo with a
//               frame-level queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_rx_fifo;

    localparam int CLK_DIV       = 4;
    localparam int FILTER_LEN    = 4;
    localparam int FIFO_DEPTH    = 16;
    localparam int TIMEOUT_TICKS = 60;
    localparam int HALF          = 40;
    localparam int QTR           = 20;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       ps2c = 1'b1;
    logic       ps2d = 1'b1;
    logic       rx_en = 1'b1;
    logic       rd_en = 1'b0;
    logic       clr_err = 1'b0;
    logic [7:0] rd_data;
    logic       empty, full;
    logic [4:0] count;
    logic       rx_done_tick, parity_err, overflow, frame_err;

    int         checks = 0;
    int         failures = 0;
    int         n_done = 0;
    int         n_ferr = 0;
    bit         model_valid = 1'b0;
    logic [7:0] m_q[$];
    bit         m_par = 1'b0;
    bit         m_ovf = 1'b0;

    always #5 clk = ~clk;

    ps2_rx_fifo #(
        .CLK_DIV       (CLK_DIV),
        .FILTER_LEN    (FILTER_LEN),
        .FIFO_DEPTH    (FIFO_DEPTH),
        .TIMEOUT_TICKS (TIMEOUT_TICKS)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .ps2c         (ps2c),
        .ps2d         (ps2d),
        .rx_en        (rx_en),
        .rd_en        (rd_en),
        .clr_err      (clr_err),
        .rd_data      (rd_data),
        .empty        (empty),
        .full         (full),
        .count        (count),
        .rx_done_tick (rx_done_tick),
        .parity_err   (parity_err),
        .overflow     (overflow),
        .frame_err    (frame_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // outputs are compared against the queue model whenever it is settled
    always @(negedge clk) begin
        if (rx_done_tick) n_done++;
        if (frame_err)    n_ferr++;
        if (model_valid) begin
            chk("empty", empty, m_q.size() == 0);
            chk("full", full, m_q.size() == FIFO_DEPTH);
            chk("count", count, m_q.size());
            if (m_q.size() != 0) chk("rd_data", rd_data, m_q[0]);
            chk("parity_err", parity_err, m_par);
            chk("overflow", overflow, m_ovf);
            chk("rx_done_quiet", rx_done_tick, 0);
            chk("frame_err_quiet", frame_err, 0);
        end
    end

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bits(input logic [10:0] bits, input int nbits, input bit drop_en);
        for (int i = 0; i < nbits; i++) begin
            ps2d = bits[i];
            clks(QTR);
            ps2c = 1'b0;
            clks(HALF);
            ps2c = 1'b1;
            clks(QTR);
            if (drop_en && i == 3) rx_en = 1'b0;
        end
        ps2d = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] data, input bit bad_par,
                              input bit bad_stop, input bit drop_en);
        logic        p;
        logic [10:0] bits;
        int          d0, f0, exp_done, exp_ferr;
        bit          accept;
        p = ~^data;
        if (bad_par) p = ~p;
        bits = {~bad_stop, p, data, 1'b0};
        d0 = n_done;
        f0 = n_ferr;
        accept = rx_en;
        model_valid = 1'b0;
        send_bits(bits, 11, drop_en);
        clks(30);
        if (drop_en) rx_en = 1'b1;
        exp_done = 0;
        exp_ferr = 0;
        if (accept) begin
            if (bad_stop)                        exp_ferr = 1;
            else if (bad_par)                    m_par = 1'b1;
            else if (m_q.size() == FIFO_DEPTH)   m_ovf = 1'b1;
            else begin
                m_q.push_back(data);
                exp_done = 1;
            end
        end
        chk("rx_done_pulses", n_done - d0, exp_done);
        chk("frame_err_pulses", n_ferr - f0, exp_ferr);
        model_valid = 1'b1;
        clks(5);
    endtask

    task automatic pop();
        model_valid = 1'b0;
        rd_en = 1'b1;
        clks(1);
        rd_en = 1'b0;
        if (m_q.size() != 0) void'(m_q.pop_front());
        model_valid = 1'b1;
        clks(1);
    endtask

    task automatic clear_err();
        model_valid = 1'b0;
        clr_err = 1'b1;
        clks(1);
        clr_err = 1'b0;
        m_par = 1'b0;
        m_ovf = 1'b0;
        model_valid = 1'b1;
        clks(1);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int f0;
        reset = 1'b0;
        clks(3);
        chk("rst_rd_data", rd_data, 8'h00);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_count", count, 0);
        chk("rst_rx_done", rx_done_tick, 0);
        chk("rst_parity", parity_err, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_frame_err", frame_err, 0);
        reset = 1'b1;
        clks(60);
        model_valid = 1'b1;
        clks(5);

        // good frame, then drain
        send_frame(8'h1C, 0, 0, 0);
        chk("t1_rd_data", rd_data, 8'h1C);
        chk("t1_count", count, 1);
        chk("t1_empty", empty, 0);
        pop();
        chk("t1_empty_after_pop", empty, 1);

        // parity error
        send_frame(8'h1C, 1, 0, 0);
        chk("t2_parity_err", parity_err, 1);
        chk("t2_empty", empty, 1);
        clear_err();
        chk("t2_parity_cleared", parity_err, 0);

        // fill past capacity
        for (int i = 0; i < 17; i++) begin
            send_frame(8'(i), 0, 0, 0);
            if (i == 15) begin
                chk("t3_full_at_16", full, 1);
                chk("t3_no_overflow_yet", overflow, 0);
            end
        end
        chk("t3_overflow", overflow, 1);
        chk("t3_count", count, 16);
        for (int i = 0; i < 16; i++) begin
            chk("t3_order", rd_data, i);
            pop();
        end
        chk("t3_empty", empty, 1);
        clear_err();

        // short low glitch on ps2c with data high is not a start bit
        f0 = n_ferr;
        ps2c = 1'b0;
        clks(5 * CLK_DIV);
        ps2c = 1'b1;
        clks(40);
        chk("t4_no_frame_err", n_ferr - f0, 0);
        send_frame(8'h5A, 0, 0, 0);
        chk("t4_followup", rd_data, 8'h5A);
        pop();

        // truncated frame must time out
        model_valid = 1'b0;
        f0 = n_ferr;
        send_bits(11'b00000110011, 5, 0);
        clks(400);
        chk("t5_timeout_pulse", n_ferr - f0, 1);
        chk("t5_empty", empty, 1);
        model_valid = 1'b1;
        clks(2);
        send_frame(8'hF0, 0, 0, 0);
        chk("t5_rd_data", rd_data, 8'hF0);
        pop();

        // stop-bit error, receiver disabled, and disable mid-frame
        send_frame(8'h55, 0, 1, 0);
        chk("t6_stop_empty", empty, 1);
        rx_en = 1'b0;
        send_frame(8'h1C, 0, 0, 0);
        rx_en = 1'b1;
        chk("t6_disabled_empty", empty, 1);
        send_frame(8'hA5, 0, 0, 1);
        chk("t6_mid_disable_data", rd_data, 8'hA5);
        pop();

        // reset in the middle of a frame with bytes queued
        send_frame(8'h11, 0, 0, 0);
        send_frame(8'h22, 0, 0, 0);
        send_frame(8'h33, 0, 0, 0);
        chk("t7_count_before", count, 3);
        model_valid = 1'b0;
        send_bits(11'b00010001000, 4, 0);
        reset = 1'b0;
        clks(3);
        chk("t7_count_reset", count, 0);
        chk("t7_empty_reset", empty, 1);
        ps2c = 1'b1;
        ps2d = 1'b1;
        m_q.delete();
        m_par = 1'b0;
        m_ovf = 1'b0;
        reset = 1'b1;
        clks(60);
        model_valid = 1'b1;
        send_frame(8'hE0, 0, 0, 0);
        chk("t7_rd_data", rd_data, 8'hE0);
        chk("t7_count", count, 1);

        model_valid = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ps2_rx_fifo.md
# ps2_rx_fifo

Buffered, parametrised PS/2 receiver for the FPGC I/O subsystem. It runs in the single system clock domain: PS/2 lines are sampled on an internal clock-enable tick, not a derived clock. Each frame is fully checked (start, odd parity, stop, inter-bit timeout). Good bytes are queued in a first-word-fall-through FIFO, so the CPU can drain scan codes at its own rate instead of catching a one-cycle tick.

## Interface
Parameters:
- CLK_DIV, 25: clk cycles per sample tick (25 MHz clk gives a 1 MHz tick).
- FILTER_LEN, 8: number of consecutive equal ps2c samples needed to change the filtered clock; range 2..16.
- FIFO_DEPTH, 16: entries; power of two, at least 2.
- TIMEOUT_TICKS, 2000: maximum sample ticks between filtered falling edges inside a frame.

Ports:
- clk, input, 1: system clock.
- reset, input, 1: asynchronous, active-low.
- ps2c, input, 1: PS/2 clock, asynchronous.
- ps2d, input, 1: PS/2 data, asynchronous.
- rx_en, input, 1: when low, new frames are not started.
- rd_en, input, 1: pop the FIFO head.
- clr_err, input, 1: clear the sticky error flags.
- rd_data, output, 8: FIFO head byte; valid while empty=0.
- empty, output, 1: FIFO empty.
- full, output, 1: FIFO full.
- count, output, $clog2(FIFO_DEPTH)+1: FIFO occupancy.
- rx_done_tick, output, 1: one-clk pulse per byte queued; used as the interrupt source.
- parity_err, output, 1: sticky.
- overflow, output, 1: sticky.
- frame_err, output, 1: one-clk pulse on a stop-bit error or timeout.

## Operation
- ps2c and ps2d each pass through a 2-flop synchroniser.
- A tick counter counts 0..CLK_DIV-1; tick is asserted for one clk at wrap.
- On each tick:
  - Shift synced ps2c into a FILTER_LEN-bit register.
  - Set the filtered clock to 1 when the register is all ones and to 0 when it is all zeros; otherwise hold it.
  - fall = filtered value was 1 and becomes 0 on this tick.
- FSM states:
  - IDLE: on fall with rx_en=1, go to RX only if synced ps2d=0 (valid start bit), clearing the bit counter and the timeout counter. A fall with ps2d=1 is ignored.
  - RX: on each fall, shift ps2d in LSB-first into a 10-bit register (8 data bits, parity, stop), increment the bit counter and clear the timeout counter. Each tick without a fall increments the timeout counter. After the 10th fall go to CHECK. If the timeout counter reaches TIMEOUT_TICKS, pulse frame_err and go to IDLE.
  - CHECK (one clk):
    - Stop bit 0: pulse frame_err and drop the byte.
    - Else, if XOR of the data bits and parity is not 1: set parity_err and drop the byte.
    - Else, if the FIFO is full and rd_en=0: set overflow and drop the byte.
    - Else: push the byte.
    - Always return to IDLE.
- rx_en going low during RX does not abort the current frame.
- FIFO behaviour:
  - FWFT: rd_data shows the head entry.
  - rd_en while empty is ignored.
  - Push and pop in the same cycle leave count unchanged and are legal even when full.
  - Pointers wrap modulo FIFO_DEPTH.
- clr_err clears parity_err and overflow. If a set event and clr_err occur in the same cycle, the set wins.

## Timing
- Reset values: rd_data=0, empty=1, full=0, count=0, rx_done_tick=0, parity_err=0, overflow=0, frame_err=0. FSM goes to IDLE; filter, filtered value and all counters are cleared.
- Reset asserted mid-frame discards the partial frame and the FIFO contents.
- Latency from the tick at which the 10th fall registers:
  - FSM is in CHECK one clk later.
  - The write occurs at the end of the CHECK cycle.
  - empty, count and rx_done_tick update on the next clk.
- rx_done_tick is a registered one-clk pulse, coincident with the first cycle in which the byte is visible.
- frame_err pulses the clk after CHECK, or the clk after the timeout tick.
- Input delay: 2 clk for synchronisation, plus FILTER_LEN ticks before the filtered clock follows a stable level.
- A pop takes effect at the next clk edge: rd_data, count and empty update at that edge.

## Structure
- Package ps2_pkg holds:
  - state enum (IDLE, RX, CHECK);
  - localparam FRAME_BITS=10;
  - a parity function.
- Sub-module sync_fifo, parametrised by WIDTH=8 and DEPTH, containing the FWFT storage, pointers and count.
- The top level contains the synchronisers, tick divider, filter, FSM and error flags.

## Test plan
Defaults, clk 25 MHz, PS/2 clock 12.5 kHz.
- Send frame 0x1C with parity 0 and stop 1 -> one rx_done_tick, empty=0, rd_data=0x1C, count=1. Pulse rd_en -> empty=1.
- Send 0x1C with parity 1 -> parity_err=1, empty stays 1, no rx_done_tick. Pulse clr_err -> parity_err=0.
- Send 17 frames 0x00..0x10 without reading -> full=1 after the 16th, overflow=1 after the 17th. Reading returns 0x00..0x0F in order, then empty=1.
- Hold ps2c low for 5 ticks while in IDLE -> no state change, no outputs.
- Send start plus 4 bits, then idle for 2.5 ms -> one frame_err pulse. A following 0xF0 frame is received correctly.
- Assert reset mid-frame with 3 bytes queued -> count=0, empty=1. The next frame 0xE0 is received.
